// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter that shares one SPI engine between NREQ clients.
// Owns the chip selects and enforces CS setup, hold and deselect timing around each frame.
module spi_xfer_arbiter #(
   parameter int NREQ     = 4,
   parameter int DATA_W   = 8,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_GAP   = 4,
   parameter int TIMEOUT  = 4096
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   output logic [NREQ-1:0]          ack,
   output logic [DATA_W-1:0]        rsp_data,
   output logic                     rsp_err,
   output logic                     busy,
   output logic [NREQ-1:0]          cs_n,
   output logic                     eng_start,
   output logic [DATA_W-1:0]        eng_tx_data,
   input  logic                     eng_done,
   input  logic [DATA_W-1:0]        eng_rx_data
);

   localparam int unsigned NR   = NREQ;
   localparam int          IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int          CM1  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int          CMAX = (CM1 > CS_GAP) ? CM1 : CS_GAP;
   localparam int          CW   = $clog2(CMAX + 1);
   localparam int          TW   = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [IW-1:0]       last_q, last_d;
   logic [DATA_W-1:0]   rx_q, rx_d;
   logic                err_q, err_d;

   logic [NREQ-1:0]     ack_d, cs_n_d;
   logic [DATA_W-1:0]   rsp_data_d, tx_d;
   logic                rsp_err_d, start_d, busy_d;

   logic                gnt_found;
   logic [IW-1:0]       gnt_idx;
   int unsigned         cand;
   logic [DATA_W-1:0]   req_bytes [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
   end

   // Search starts just past the last completed grant, wrapping modulo NREQ.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = last_q;
      cand      = 0;
      for (int unsigned i = 1; i <= NR; i++) begin
         cand = (32'(last_q) + i) % NR;
         if (!gnt_found && req[cand[IW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[IW-1:0];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      timer_d    = timer_q;
      idx_d      = idx_q;
      last_d     = last_q;
      rx_d       = rx_q;
      err_d      = err_q;
      ack_d      = '0;
      start_d    = 1'b0;
      cs_n_d     = cs_n;
      tx_d       = eng_tx_data;
      rsp_data_d = rsp_data;
      rsp_err_d  = rsp_err;
      case (state_q)
         IDLE: begin
            if (gnt_found) begin
               idx_d           = gnt_idx;
               tx_d            = req_bytes[gnt_idx];
               cs_n_d          = '1;
               cs_n_d[gnt_idx] = 1'b0;
               cnt_d           = '0;
               state_d         = SETUP;
            end
         end
         SETUP: begin
            if (cnt_q == CW'(CS_SETUP - 1)) begin
               start_d = 1'b1;
               timer_d = '0;
               state_d = XFER;
            end
         end
         XFER: begin
            timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
            // eng_done wins over a timeout landing on the same edge.
            if (eng_done) begin
               rx_d    = eng_rx_data;
               err_d   = 1'b0;
               cnt_d   = '0;
               state_d = HOLD;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               rx_d    = '0;
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (cnt_q == CW'(CS_HOLD - 1)) begin
               cs_n_d       = '1;
               ack_d[idx_q] = 1'b1;
               rsp_data_d   = rx_q;
               rsp_err_d    = err_q;
               last_d       = idx_q;
               cnt_d        = '0;
               state_d      = GAP;
            end
         end
         GAP: begin
            if (cnt_q == CW'(CS_GAP - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         timer_q     <= '0;
         idx_q       <= '0;
         last_q      <= IW'(NREQ - 1);
         rx_q        <= '0;
         err_q       <= 1'b0;
         ack         <= '0;
         cs_n        <= '1;
         eng_start   <= 1'b0;
         eng_tx_data <= '0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         timer_q     <= timer_d;
         idx_q       <= idx_d;
         last_q      <= last_d;
         rx_q        <= rx_d;
         err_q       <= err_d;
         ack         <= ack_d;
         cs_n        <= cs_n_d;
         eng_start   <= start_d;
         eng_tx_data <= tx_d;
         rsp_data    <= rsp_data_d;
         rsp_err     <= rsp_err_d;
         busy        <= busy_d;
      end
   end

endmodule
